yoda_encoder: RTL and testbench

Byte-stream run-length encoder; it is the producer side of the YODA encoded bitstream that the decoder consumes.
- Input: a block of `len` raw bytes from a host through a request/accept handshake.
- Output: a 2-byte big-endian length header, then (run_count, value) pairs, through a present/acknowledge handshake.
- Sits between the raw-data source and the encoded-stream sink (file writer or decoder).

---
 rtl/yoda_encoder.sv | 146 ++++++++++++++
 tb/tb_yoda_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/yoda_encoder.sv
// rtl/yoda_encoder.sv - YODA run-length encoder: raw bytes in, length header plus (count, value) pairs out
module yoda_encoder #(
   parameter int MAX_RUN = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] len,
   input  logic        rd,
   input  logic [7:0]  dat_in,
   output logic        wt,
   output logic [7:0]  dat_out,
   output logic        dn,
   input  logic        sent,
   output logic        finish
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR_HI, S_HDR_LO, S_FETCH, S_ACCUM, S_EMIT_CNT, S_EMIT_VAL, S_DONE
   } state_t;

   state_t      state, state_nxt, emit_next;
   logic [15:0] len_q, len_nxt;
   logic [15:0] remaining, rem_nxt, rem_dec;
   logic [7:0]  run_cnt, cnt_nxt;
   logic [7:0]  run_val, val_nxt;
   logic [7:0]  dat_nxt, emit_byte;
   logic        dn_nxt, wt_nxt, fin_nxt;
   logic        take, is_emit;

   // wt is still high the cycle after a capture, which blocks re-capturing the same byte
   assign take    = rd && !wt;
   assign rem_dec = remaining - 16'd1;

   always_comb begin
      is_emit   = 1'b0;
      emit_byte = 8'h00;
      emit_next = S_IDLE;
      case (state)
         S_HDR_HI: begin
            is_emit   = 1'b1;
            emit_byte = len_q[15:8];
            emit_next = S_HDR_LO;
         end
         S_HDR_LO: begin
            is_emit   = 1'b1;
            emit_byte = len_q[7:0];
            emit_next = (len_q == 16'd0) ? S_DONE : S_FETCH;
         end
         S_EMIT_CNT: begin
            is_emit   = 1'b1;
            emit_byte = run_cnt;
            emit_next = S_EMIT_VAL;
         end
         S_EMIT_VAL: begin
            is_emit   = 1'b1;
            emit_byte = run_val;
            emit_next = (remaining == 16'd0) ? S_DONE : S_FETCH;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      rem_nxt   = remaining;
      cnt_nxt   = run_cnt;
      val_nxt   = run_val;
      dat_nxt   = dat_out;
      dn_nxt    = dn;
      wt_nxt    = 1'b0;

      if (is_emit) begin
         // dn rises one cycle after entering an emit state and falls after sent,
         // so consecutive output bytes always have a dn-low gap
         if (!dn) begin
            dn_nxt  = 1'b1;
            dat_nxt = emit_byte;
         end else if (sent) begin
            dn_nxt    = 1'b0;
            state_nxt = emit_next;
         end
      end

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               len_nxt   = len;
               rem_nxt   = len;
               state_nxt = S_HDR_HI;
            end
         end
         S_FETCH: begin
            if (take) begin
               val_nxt   = dat_in;
               cnt_nxt   = 8'd1;
               rem_nxt   = rem_dec;
               wt_nxt    = 1'b1;
               state_nxt = (rem_dec == 16'd0) ? S_EMIT_CNT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (take) begin
               if (dat_in == run_val && run_cnt < 8'(MAX_RUN)) begin
                  cnt_nxt   = run_cnt + 8'd1;
                  rem_nxt   = rem_dec;
                  wt_nxt    = 1'b1;
                  state_nxt = (rem_dec == 16'd0) ? S_EMIT_CNT : S_ACCUM;
               end else begin
                  // byte stays on the host side and is picked up by the next FETCH
                  state_nxt = S_EMIT_CNT;
               end
            end
         end
         default: ;
      endcase

      fin_nxt = (state_nxt == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         len_q     <= 16'd0;
         remaining <= 16'd0;
         run_cnt   <= 8'd0;
         run_val   <= 8'd0;
         dat_out   <= 8'h00;
         dn        <= 1'b0;
         wt        <= 1'b0;
         finish    <= 1'b0;
      end else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         remaining <= rem_nxt;
         run_cnt   <= cnt_nxt;
         run_val   <= val_nxt;
         dat_out   <= dat_nxt;
         dn        <= dn_nxt;
         wt        <= wt_nxt;
         finish    <= fin_nxt;
      end
   end

endmodule

// File: tb/tb_yoda_encoder.sv
// tb/tb_yoda_encoder.sv - randomized self-checking bench for yoda_encoder against a run-length model
module tb_yoda_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] len = 16'd0;
   logic        rd = 1'b0;
   logic [7:0]  dat_in = 8'h00;
   logic        wt;
   logic [7:0]  dat_out;
   logic        dn;
   logic        sent = 1'b0;
   logic        finish;

   yoda_encoder #(.MAX_RUN(255)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .rd(rd), .dat_in(dat_in),
      .wt(wt), .dat_out(dat_out), .dn(dn), .sent(sent), .finish(finish)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [7:0] stim[$];
   logic [7:0] got[$];
   int         wt_at[$];
   int         wt_cnt, wt_dn, unstable, timeout;
   bit         blk_done;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic run_block(input int n, input int dly, input bit rd_hold);
      logic [7:0] exp[$];
      int         cum[$];
      int         i, c, acc;
      exp.delete(); cum.delete();
      exp.push_back(8'(n >> 8));
      exp.push_back(8'(n));
      i = 0; acc = 0;
      while (i < n) begin
         c = 1;
         while (i + c < n && stim[i + c] == stim[i] && c < 255) c++;
         exp.push_back(8'(c));
         exp.push_back(stim[i]);
         acc += c;
         cum.push_back(acc);
         i += c;
      end

      got.delete(); wt_at.delete();
      wt_cnt = 0; wt_dn = 0; unstable = 0; timeout = 0; blk_done = 0;
      @(negedge clk);
      len = 16'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      fork
         begin
            if (n == 0 && rd_hold) begin
               rd = 1'b1; dat_in = 8'($urandom);
               while (!blk_done) @(negedge clk);
            end
            for (int k = 0; k < n && !blk_done; k++) begin
               rd = 1'b1; dat_in = stim[k];
               do @(negedge clk); while (!wt && !blk_done);
               if (!rd_hold) begin
                  rd = 1'b0;
                  repeat (1 + $urandom % 2) @(negedge clk);
               end
            end
            rd = 1'b0;
         end
         begin
            int cyc = 0, w = 0;
            bit in_byte = 0;
            logic [7:0] cur = 8'h00;
            while (!blk_done) begin
               @(negedge clk);
               cyc++;
               sent = 1'b0;
               if (wt) wt_cnt++;
               if (wt && dn) wt_dn++;
               if (dn) begin
                  if (!in_byte) begin
                     in_byte = 1; cur = dat_out; w = 0;
                  end else if (dat_out != cur) unstable++;
                  if (w >= dly) begin
                     sent = 1'b1;
                     got.push_back(cur);
                     in_byte = 0;
                     if (got.size() >= 4 && got.size() % 2 == 0) wt_at.push_back(wt_cnt);
                  end
                  w++;
               end else if ($urandom % 8 == 0) begin
                  sent = 1'b1;
               end
               if (finish) blk_done = 1;
               if (cyc > 20000) begin
                  timeout = 1; blk_done = 1;
               end
            end
            sent = 1'b0;
         end
      join

      check("timeout", timeout, 0);
      check("out_len", got.size(), exp.size());
      for (int k = 0; k < exp.size() && k < got.size(); k++) check($sformatf("out[%0d]", k), got[k], exp[k]);
      check("wt_total", wt_cnt, n);
      check("wt_during_dn", wt_dn, 0);
      check("dat_out_stable", unstable, 0);
      check("pairs", wt_at.size(), cum.size());
      for (int k = 0; k < cum.size() && k < wt_at.size(); k++) check($sformatf("wt_at_pair%0d", k), wt_at[k], cum[k]);
      check("finish", finish, 1);
   endtask

   task automatic sink_one(output logic [7:0] b);
      int k = 0;
      b = 8'h00;
      while (!dn && k < 200) begin @(negedge clk); k++; end
      check("sink_wait", (k < 200), 1);
      b = dat_out;
      sent = 1'b1;
      @(negedge clk);
      sent = 1'b0;
   endtask

   task automatic host_one(input logic [7:0] v);
      int k = 0;
      rd = 1'b1; dat_in = v;
      do begin @(negedge clk); k++; end while (!wt && k < 200);
      check("host_wait", (k < 200), 1);
      rd = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      repeat (3) @(negedge clk);
      check("rst_dn", dn, 0);
      check("rst_wt", wt, 0);
      check("rst_dat", dat_out, 0);
      check("rst_finish", finish, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      stim = '{8'hA5, 8'hA5, 8'hA5, 8'h3C};
      run_block(4, 0, 0);

      stim.delete();
      run_block(0, 0, 1);

      stim.delete();
      for (int k = 0; k < 300; k++) stim.push_back(8'h00);
      run_block(300, 0, 0);

      stim = '{8'h01, 8'h02, 8'h01};
      run_block(3, 1, 0);

      stim = '{8'hA5, 8'hA5, 8'hA5, 8'h3C};
      run_block(4, 10, 1);

      for (int t = 0; t < 10; t++) begin
         int n = 1 + $urandom % 40;
         stim.delete();
         for (int k = 0; k < n; k++) stim.push_back(8'($urandom % 3) + 8'h40);
         run_block(n, $urandom % 4, 1'($urandom % 2));
      end

      // reset abandons a block mid-run
      @(negedge clk);
      len = 16'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sink_one(b);
      check("s6_hdr_hi", b, 8'h00);
      sink_one(b);
      check("s6_hdr_lo", b, 8'h04);
      host_one(8'hA5);
      host_one(8'hA5);
      rst_n = 1'b0;
      #1;
      check("s6_rst_dn", dn, 0);
      check("s6_rst_wt", wt, 0);
      check("s6_rst_dat", dat_out, 0);
      check("s6_rst_finish", finish, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("s6_idle_dn", dn, 0);
      stim = '{8'h7E, 8'h7E};
      run_block(2, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
